// File: rtl/axil_led_pkg.sv
// Shared definitions for the AXI-Lite LED/GPIO output controller.
package axil_led_pkg;

   // Register byte offsets
   localparam int unsigned OFF_DATA     = 32'h000;
   localparam int unsigned OFF_PRESC    = 32'h004;
   localparam int unsigned OFF_STATUS   = 32'h008;
   localparam int unsigned OFF_CFG_BASE = 32'h100;

   // AXI response codes
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Channel modes; the fourth encoding behaves as static
   typedef enum logic [1:0] {
      MODE_STATIC = 2'd0,
      MODE_BLINK  = 2'd1,
      MODE_PWM    = 2'd2,
      MODE_RSVD   = 2'd3
   } mode_e;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_RESP = 1'b1
   } wr_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_e;

   // Byte-strobe merge of write data into the current register view
   function automatic logic [31:0] apply_strb(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/axil_led_pwm_gpio_chan.sv
// One LED channel: static level, blink phase flop or PWM compare, registered out.
module led_chan_gen
   import axil_led_pkg::*;
#(
   parameter int PWM_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  mode_e            mode,
   input  logic [PWM_W-1:0] duty,
   input  logic [PWM_W-1:0] pwm_cnt,
   input  logic             level,
   input  logic             strobe,
   input  logic             clr_blink,
   output logic             led
);

   logic blink_q;
   logic led_next;

   // Blink phase: a mode write restarts it low, otherwise flips once per PWM period
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            blink_q <= 1'b0;
      else if (clr_blink) blink_q <= 1'b0;
      else if (strobe)    blink_q <= ~blink_q;
   end

   // Mode mux; all-ones duty is pinned on so full scale has no dark slot
   always_comb begin
      led_next = level;
      case (mode)
         MODE_BLINK: led_next = blink_q;
         MODE_PWM:   led_next = (duty == '1) || (pwm_cnt < duty);
         default:    led_next = level;
      endcase
   end

   // Registered LED drive
   always_ff @(posedge clk or posedge rst) begin
      if (rst) led <= 1'b0;
      else     led <= led_next;
   end

endmodule

// File: rtl/axil_led_pwm_gpio.sv
// AXI4-Lite LED/GPIO controller: per-channel static/blink/PWM with shared timebase.
//
// state  | meaning
// W_IDLE | waiting for address and data together; accepts both in one cycle
// W_RESP | write done, bvalid held until bready
// R_IDLE | waiting for arvalid; accepts immediately
// R_DATA | registered rdata/rresp presented, rvalid held until rready
module axil_led_pwm_gpio
   import axil_led_pkg::*;
#(
   parameter int NUM_CH  = 8,
   parameter int ADDR_W  = 12,
   parameter int PWM_W   = 8,
   parameter int PRESC_W = 16
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic [ADDR_W-1:0] s_axi_awaddr,
   input  logic              s_axi_awvalid,
   output logic              s_axi_awready,
   input  logic [31:0]       s_axi_wdata,
   input  logic [3:0]        s_axi_wstrb,
   input  logic              s_axi_wvalid,
   output logic              s_axi_wready,
   output logic [1:0]        s_axi_bresp,
   output logic              s_axi_bvalid,
   input  logic              s_axi_bready,
   input  logic [ADDR_W-1:0] s_axi_araddr,
   input  logic              s_axi_arvalid,
   output logic              s_axi_arready,
   output logic [31:0]       s_axi_rdata,
   output logic [1:0]        s_axi_rresp,
   output logic              s_axi_rvalid,
   input  logic              s_axi_rready,
   output logic [NUM_CH-1:0] led_o
);

   localparam int          IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned CFG_END = OFF_CFG_BASE + 32'(4 * NUM_CH);

   wr_state_e w_state, w_next;
   rd_state_e r_state, r_next;

   logic [NUM_CH-1:0]  data_reg;
   logic [PRESC_W-1:0] presc_reg, presc_cnt;
   logic [PWM_W-1:0]   pwm_cnt;
   mode_e              cfg_mode [NUM_CH];
   logic [PWM_W-1:0]   cfg_duty [NUM_CH];
   logic [31:0]        cfg_word [NUM_CH];

   logic [31:0]       aw_a, ar_a, rd_val, wr_old, wr_new;
   logic [IDX_W-1:0]  aw_idx, ar_idx;
   logic              aw_cfg, ar_cfg, rd_hit, wr_hit;
   logic              aw_hs, ar_hs, presc_wr, tick, strobe;
   logic [NUM_CH-1:0] clr_blink;
   logic              unused_bits;

   assign aw_a   = 32'(s_axi_awaddr) & ~32'd3;
   assign ar_a   = 32'(s_axi_araddr) & ~32'd3;
   assign aw_cfg = (aw_a >= OFF_CFG_BASE) && (aw_a < CFG_END);
   assign ar_cfg = (ar_a >= OFF_CFG_BASE) && (ar_a < CFG_END);
   assign aw_idx = IDX_W'((aw_a - OFF_CFG_BASE) >> 2);
   assign ar_idx = IDX_W'((ar_a - OFF_CFG_BASE) >> 2);
   assign aw_hs  = s_axi_awready;
   assign ar_hs  = s_axi_arready;

   // FSM state registers
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
      end else begin
         w_state <= w_next;
         r_state <= r_next;
      end
   end

   // Write FSM: address and data are only taken together
   always_comb begin
      w_next        = w_state;
      s_axi_awready = 1'b0;
      s_axi_wready  = 1'b0;
      s_axi_bvalid  = 1'b0;
      case (w_state)
         W_IDLE: if (s_axi_awvalid && s_axi_wvalid && !ARESET) begin
            s_axi_awready = 1'b1;
            s_axi_wready  = 1'b1;
            w_next        = W_RESP;
         end
         W_RESP: begin
            s_axi_bvalid = 1'b1;
            if (s_axi_bready) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   // Read FSM
   always_comb begin
      r_next        = r_state;
      s_axi_arready = 1'b0;
      s_axi_rvalid  = 1'b0;
      case (r_state)
         R_IDLE: if (s_axi_arvalid && !ARESET) begin
            s_axi_arready = 1'b1;
            r_next        = R_DATA;
         end
         R_DATA: begin
            s_axi_rvalid = 1'b1;
            if (s_axi_rready) r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   // Packed readback view of each channel config
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         cfg_word[c]             = '0;
         cfg_word[c][1:0]        = cfg_mode[c];
         cfg_word[c][8 +: PWM_W] = cfg_duty[c];
      end
   end

   // Read-side decode
   always_comb begin
      rd_hit = 1'b1;
      rd_val = '0;
      if (ar_a == OFF_DATA)        rd_val = 32'(data_reg);
      else if (ar_a == OFF_PRESC)  rd_val = 32'(presc_reg);
      else if (ar_a == OFF_STATUS) rd_val = 32'(led_o);
      else if (ar_cfg)             rd_val = cfg_word[ar_idx];
      else                         rd_hit = 1'b0;
   end

   // Write-side decode; STATUS is accepted but has nothing behind it
   always_comb begin
      wr_hit = 1'b1;
      wr_old = '0;
      if (aw_a == OFF_DATA)        wr_old = 32'(data_reg);
      else if (aw_a == OFF_PRESC)  wr_old = 32'(presc_reg);
      else if (aw_a == OFF_STATUS) wr_old = '0;
      else if (aw_cfg)             wr_old = cfg_word[aw_idx];
      else                         wr_hit = 1'b0;
   end

   assign wr_new      = apply_strb(wr_old, s_axi_wdata, s_axi_wstrb);
   assign unused_bits = ^wr_new;

   // Register file update on the write handshake
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         data_reg  <= '0;
         presc_reg <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            cfg_mode[c] <= MODE_STATIC;
            cfg_duty[c] <= '0;
         end
      end else if (aw_hs) begin
         if (aw_a == OFF_DATA)  data_reg  <= wr_new[NUM_CH-1:0];
         if (aw_a == OFF_PRESC) presc_reg <= wr_new[PRESC_W-1:0];
         if (aw_cfg) begin
            cfg_mode[aw_idx] <= mode_e'(wr_new[1:0]);
            cfg_duty[aw_idx] <= wr_new[8 +: PWM_W];
         end
      end
   end

   // Response registers; a read captures the pre-write value in a collision
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         s_axi_bresp <= RESP_OKAY;
         s_axi_rdata <= '0;
         s_axi_rresp <= RESP_OKAY;
      end else begin
         if (aw_hs) s_axi_bresp <= wr_hit ? RESP_OKAY : RESP_SLVERR;
         if (ar_hs) begin
            s_axi_rdata <= rd_val;
            s_axi_rresp <= rd_hit ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   assign tick     = (presc_cnt == '0);
   assign strobe   = tick && (pwm_cnt == '1);
   assign presc_wr = aw_hs && (aw_a == OFF_PRESC);

   // Prescaler down-counter: tick at terminal count, restart on a PRESC write
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET)        presc_cnt <= '0;
      else if (presc_wr) presc_cnt <= wr_new[PRESC_W-1:0];
      else if (tick)     presc_cnt <= presc_reg;
      else               presc_cnt <= presc_cnt - 1'b1;
   end

   // Shared PWM counter, wraps naturally
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET)    pwm_cnt <= '0;
      else if (tick) pwm_cnt <= pwm_cnt + 1'b1;
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
      assign clr_blink[c] = aw_hs && aw_cfg && (aw_idx == IDX_W'(c)) && s_axi_wstrb[0];

      led_chan_gen #(.PWM_W(PWM_W)) u_chan (
         .clk       (ACLK),
         .rst       (ARESET),
         .mode      (cfg_mode[c]),
         .duty      (cfg_duty[c]),
         .pwm_cnt   (pwm_cnt),
         .level     (data_reg[c]),
         .strobe    (strobe),
         .clr_blink (clr_blink[c]),
         .led       (led_o[c])
      );
   end

endmodule

// File: tb/tb_axil_led_pwm_gpio.sv
// Self-checking bench for axil_led_pwm_gpio (NUM_CH=8, PWM_W=8).
module tb_axil_led_pwm_gpio;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] awaddr = '0, araddr = '0;
   logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   logic [7:0]  led_o;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference register state
   logic [7:0]  m_data;
   logic [15:0] m_presc;
   logic [1:0]  m_mode [8];
   logic [7:0]  m_duty [8];

   axil_led_pwm_gpio #(.NUM_CH(8), .ADDR_W(12), .PWM_W(8), .PRESC_W(16)) dut (
      .ACLK(clk), .ARESET(rst),
      .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .led_o(led_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // {hit, value} of the register at byte address a
   function automatic logic [32:0] m_view(input logic [11:0] a);
      int w;
      w = int'(a) & ~3;
      if (w == 0) return {1'b1, 24'd0, m_data};
      if (w == 4) return {1'b1, 16'd0, m_presc};
      if (w == 8) return {1'b1, 32'd0};
      if (w >= 'h100 && w < 'h120)
         return {1'b1, 16'd0, m_duty[(w - 'h100) / 4], 6'd0, m_mode[(w - 'h100) / 4]};
      return 33'd0;
   endfunction

   function automatic logic [1:0] m_write(input logic [11:0] a, input logic [31:0] d,
                                          input logic [3:0] s);
      logic [32:0] v;
      logic [31:0] nv;
      int w;
      v = m_view(a);
      w = int'(a) & ~3;
      if (!v[32]) return 2'b10;
      nv = merge(v[31:0], d, s);
      if (w == 0) m_data = nv[7:0];
      else if (w == 4) m_presc = nv[15:0];
      else if (w >= 'h100) begin
         m_mode[(w - 'h100) / 4] = nv[1:0];
         m_duty[(w - 'h100) / 4] = nv[15:8];
      end
      return 2'b00;
   endfunction

   task automatic m_reset();
      m_data = '0; m_presc = '0;
      for (int c = 0; c < 8; c++) begin m_mode[c] = '0; m_duty[c] = '0; end
   endtask

   task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
      int n;
      @(negedge clk);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
      #1; n = 0;
      while (!awready && n < 50) begin @(negedge clk); #1; n++; end
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0;
      n = 0;
      while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
      check("bvalid_seen", {31'd0, bvalid}, 32'd1);
      resp = bresp;
      @(posedge clk); #1;
      bready = 0;
   endtask

   task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n;
      @(negedge clk);
      araddr = a; arvalid = 1; rready = 1;
      #1; n = 0;
      while (!arready && n < 50) begin @(negedge clk); #1; n++; end
      @(posedge clk); #1;
      arvalid = 0;
      n = 0;
      while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
      check("rvalid_seen", {31'd0, rvalid}, 32'd1);
      d = rdata; resp = rresp;
      @(posedge clk); #1;
      rready = 0;
   endtask

   initial begin
      logic [1:0]  resp, eresp;
      logic [31:0] d, rd;
      logic [32:0] v;
      logic [11:0] a;
      logic [3:0]  s;
      logic        prev;
      int          cnt, n;

      m_reset();
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_led", {24'd0, led_o}, 32'd0);
      check("rst_bvalid", {31'd0, bvalid}, 32'd0);
      check("rst_rvalid", {31'd0, rvalid}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_ready", {29'd0, awready, wready, arready}, 32'd0);
      @(negedge clk); rst = 0;

      // Zero strobes leave DATA untouched
      axi_write(12'h000, 32'h5A, 4'b0000, resp);
      check("strb0_bresp", {30'd0, resp}, 32'd0);
      axi_read(12'h000, rd, resp);
      check("strb0_data", rd, 32'd0);

      // Static all-on, STATUS mirrors led_o
      eresp = m_write(12'h000, 32'hFFFF_FFFF, 4'hF);
      axi_write(12'h000, 32'hFFFF_FFFF, 4'hF, resp);
      check("static_led", {24'd0, led_o}, 32'hFF);
      axi_read(12'h008, rd, resp);
      check("status_rdata", rd, 32'hFF);
      check("status_rresp", {30'd0, resp}, 32'd0);

      // Randomized register traffic against the model
      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 4))
            0: a = 12'h000;
            1: a = 12'h004;
            2: a = 12'(12'h100 + 4 * $urandom_range(0, 7));
            3: a = 12'($urandom_range(0, 12'hFFF));
            default: a = 12'h008;
         endcase
         a = a | 12'($urandom_range(0, 3));
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         eresp = m_write(a, d, s);
         axi_write(a, d, s, resp);
         check("rand_bresp", {30'd0, resp}, {30'd0, eresp});
         a = 12'($urandom_range(0, 12'hFFF));
         if ((a & ~12'd3) == 12'h008) a = 12'h004;
         if ($urandom_range(0, 1) == 1) a = 12'(12'h100 + 4 * $urandom_range(0, 7));
         v = m_view(a);
         axi_read(a, rd, resp);
         check("rand_rdata", rd, v[32] ? v[31:0] : 32'd0);
         check("rand_rresp", {30'd0, resp}, v[32] ? 32'd0 : 32'd2);
      end

      // Back to a known config
      for (int c = 0; c < 8; c++) begin
         eresp = m_write(12'(12'h100 + 4 * c), 32'd0, 4'hF);
         axi_write(12'(12'h100 + 4 * c), 32'd0, 4'hF, resp);
      end
      eresp = m_write(12'h000, 32'd0, 4'hF);
      axi_write(12'h000, 32'd0, 4'hF, resp);

      // Unmapped accesses
      axi_write(12'h040, 32'hFFFF_FFFF, 4'hF, resp);
      check("unmapped_bresp", {30'd0, resp}, 32'd2);
      axi_read(12'h3FC, rd, resp);
      check("unmapped_rresp", {30'd0, resp}, 32'd2);
      check("unmapped_rdata", rd, 32'd0);
      axi_read(12'h000, rd, resp);
      check("unmapped_nochg_data", rd, {24'd0, m_data});
      axi_read(12'h004, rd, resp);
      check("unmapped_nochg_presc", rd, {16'd0, m_presc});

      // PWM duty sweep on channel 0 at full rate
      eresp = m_write(12'h004, 32'd0, 4'hF);
      axi_write(12'h004, 32'd0, 4'hF, resp);
      for (int k = 0; k < 3; k++) begin
         d = (k == 0) ? 32'h40 : (k == 1) ? 32'hFF : 32'h00;
         eresp = m_write(12'h100, 32'h2 | (d << 8), 4'hF);
         axi_write(12'h100, 32'h2 | (d << 8), 4'hF, resp);
         repeat (3) @(posedge clk);
         cnt = 0;
         for (int t = 0; t < 256; t++) begin
            @(posedge clk); #1;
            cnt += int'(led_o[0]);
         end
         check("pwm_on_count", 32'(cnt), (d == 32'hFF) ? 32'd256 : d);
      end

      // Blink on channel 3 with a 2-cycle tick
      eresp = m_write(12'h004, 32'd1, 4'hF);
      axi_write(12'h004, 32'd1, 4'hF, resp);
      eresp = m_write(12'h10C, 32'd1, 4'hF);
      axi_write(12'h10C, 32'd1, 4'hF, resp);
      prev = led_o[3]; n = 0;
      while (led_o[3] == prev && n < 1200) begin @(posedge clk); #1; n++; end
      prev = led_o[3]; n = 0;
      while (led_o[3] == prev && n < 1200) begin @(posedge clk); #1; n++; end
      check("blink_half_period", 32'(n), 32'd512);
      n = 0;
      while (led_o[3] != 1'b1 && n < 1200) begin @(posedge clk); #1; n++; end
      check("blink_high_before_clear", {31'd0, led_o[3]}, 32'd1);
      axi_write(12'h10C, 32'd1, 4'hF, resp);
      check("blink_cleared", {31'd0, led_o[3]}, 32'd0);

      // Read and write of DATA in the same cycle
      eresp = m_write(12'h100, 32'd0, 4'hF);
      axi_write(12'h100, 32'd0, 4'hF, resp);
      eresp = m_write(12'h10C, 32'd0, 4'hF);
      axi_write(12'h10C, 32'd0, 4'hF, resp);
      eresp = m_write(12'h000, 32'h11, 4'hF);
      axi_write(12'h000, 32'h11, 4'hF, resp);
      @(negedge clk);
      araddr = 12'h000; arvalid = 1; rready = 0;
      awaddr = 12'h000; wdata = 32'h22; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
      @(posedge clk); #1;
      arvalid = 0; awvalid = 0; wvalid = 0;
      check("collide_rvalid", {31'd0, rvalid}, 32'd1);
      check("collide_old_rdata", rdata, 32'h11);
      check("collide_bvalid", {31'd0, bvalid}, 32'd1);
      rready = 1;
      @(posedge clk); #1;
      rready = 0; bready = 0;
      eresp = m_write(12'h000, 32'h22, 4'hF);
      axi_read(12'h000, rd, resp);
      check("collide_new_data", rd, 32'h22);

      // Reset while a write response is pending
      eresp = m_write(12'h000, 32'h3C, 4'hF);
      @(negedge clk);
      awaddr = 12'h000; wdata = 32'h3C; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0;
      repeat (3) @(posedge clk);
      #1;
      check("pend_bvalid", {31'd0, bvalid}, 32'd1);
      check("pend_led", {24'd0, led_o}, {24'd0, m_data});
      #2 rst = 1;
      #1;
      check("arst_bvalid", {31'd0, bvalid}, 32'd0);
      check("arst_led", {24'd0, led_o}, 32'd0);
      @(negedge clk); rst = 0;
      m_reset();
      eresp = m_write(12'h000, 32'h81, 4'hF);
      axi_write(12'h000, 32'h81, 4'hF, resp);
      check("post_rst_bresp", {30'd0, resp}, {30'd0, eresp});
      check("post_rst_led", {24'd0, led_o}, 32'h81);
      axi_read(12'h000, rd, resp);
      check("post_rst_data", rd, 32'h81);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
